// File: rtl/seq_tag_search.sv
// Sequential CAM-style lookup: one shared equaln compare per cycle over a DEPTH-entry tag table, lowest index wins.
// Hit at index i responds i+1 cycles after accept, a miss after DEPTH; the response holds until rsp_ready.
module seq_tag_search #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_key,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_hit,
   output logic [IDX_W-1:0] rsp_idx,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] key_q, key_d;
   logic             hit_q, hit_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0] tag_q [DEPTH];
   logic             cmp_eq;
   logic             eq;

   equaln #(.WIDTH(WIDTH)) u_equaln (
      .a_i  (tag_q[ptr_q]),
      .b_i  (key_q),
      .eq_o (cmp_eq)
   );

   assign eq        = cmp_eq & valid_q[ptr_q];
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_hit   = hit_q;
   assign rsp_idx   = idx_q;

   // Decoding wr_idx against each entry drops out-of-range writes for free.
   always_comb begin
      valid_d = clr ? '0 : valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) valid_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && (wr_idx == IDX_W'(i))) tag_q[i] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      key_d   = key_q;
      hit_d   = hit_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               key_d   = req_key;
               ptr_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (eq) begin
               hit_d   = 1'b1;
               idx_d   = ptr_q;
               state_d = RESP;
            end else if (ptr_q == IDX_W'(DEPTH - 1)) begin
               hit_d   = 1'b0;
               idx_d   = '0;
               state_d = RESP;
            end else begin
               ptr_d = ptr_q + IDX_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         key_q   <= '0;
         hit_q   <= 1'b0;
         idx_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         key_q   <= key_d;
         hit_q   <= hit_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule

module equaln #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             eq_o
);
   assign eq_o = (a_i == b_i);
endmodule
